fpga_data_sink: RTL and testbench

Byte-wide AXI4-Stream receiver with an Avalon-MM CSR window, the capture-side counterpart of the FPGA data source. When the HPS arms it, the block accepts one stream frame into a 4 KiB on-chip buffer and records the frame length and an overflow flag. It then raises an optional interrupt. Software reads captured bytes back one at a time through the CSRs. It sits on the lightweight HPS-to-FPGA bridge beside the source, so the two can be looped back for self-test.

---
 rtl/fpga_data_sink_pkg.sv | 21 ++
 rtl/fpga_data_sink_sdp_ram_byte.sv | 19 +
 rtl/fpga_data_sink.sv | 113 +++++++++++
 tb/tb_fpga_data_sink.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_data_sink_pkg.sv
// fpga_data_sink_pkg: CSR map, register bit positions and FSM states shared by the capture sink.
package fpga_data_sink_pkg;
  localparam logic [1:0] CSR_CTRL = 2'd0;
  localparam logic [1:0] CSR_STAT = 2'd1;
  localparam logic [1:0] CSR_IE   = 2'd2;
  localparam logic [1:0] CSR_DBG  = 2'd3;
  localparam int CTRL_ARM     = 0;
  localparam int CTRL_RD_REQ  = 1;
  localparam int CTRL_RD_ADDR = 4;
  localparam int CTRL_CLR     = 31;
  localparam logic [31:0] CTRL_MASK = 32'h8000_FFF3;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_RD_PEND = 3;
  localparam int STAT_RD_DATA = 8;
  localparam int STAT_LEN     = 16;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
endpackage

// File: rtl/fpga_data_sink_sdp_ram_byte.sv
// sdp_ram_byte: simple dual-port byte buffer with a registered read-first output.
module sdp_ram_byte #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] rd_q;
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end
  assign rd_data = rd_q;
endmodule

// File: rtl/fpga_data_sink.sv
// fpga_data_sink: AXI4-Stream byte capture into on-chip buffer with Avalon-MM CSR control and readback.
module fpga_data_sink
  import fpga_data_sink_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_write_n,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic [7:0]  axis4_s_tdata,
  input  logic        axis4_s_tvalid,
  input  logic        axis4_s_tlast,
  output logic        axis4_s_tready,
  output logic        irq
);
  logic [1:0] state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d, stat, dbg;
  logic ie_q, ie_d, tready_q, tready_d, done_q, done_d, ovf_q, ovf_d;
  logic rd_pend_q, rd_pend_d, rd_p1_q, rd_p1_d, rd_p2_q, rd_p2_d;
  logic [7:0] rd_data_q, rd_data_d, ram_rd;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic wr_ctrl, wr_ie, clr, arm, rd_req, start, hs, at_end, term;
  assign wr_ctrl = avs_chipselect & ~avs_write_n & (avs_address == CSR_CTRL);
  assign wr_ie   = avs_chipselect & ~avs_write_n & (avs_address == CSR_IE);
  assign clr     = wr_ctrl & avs_writedata[CTRL_CLR];
  assign arm     = wr_ctrl & avs_writedata[CTRL_ARM] & ~clr;
  assign rd_req  = wr_ctrl & avs_writedata[CTRL_RD_REQ] & ~clr;
  assign start   = arm & (state_q == S_IDLE || state_q == S_DONE);
  assign hs      = axis4_s_tvalid & tready_q;
  assign at_end  = &wr_ptr_q;
  assign term    = hs & (axis4_s_tlast | at_end);
  sdp_ram_byte #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .we      (hs),
    .wr_addr (wr_ptr_q),
    .wr_data (axis4_s_tdata),
    .rd_addr (ctrl_q[CTRL_RD_ADDR +: ADDR_WIDTH]),
    .rd_data (ram_rd)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      ie_q        <= 1'b0;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      rd_data_q   <= '0;
      wr_ptr_q    <= '0;
      frame_len_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ie_q        <= ie_d;
      tready_q    <= tready_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      rd_pend_q   <= rd_pend_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      rd_data_q   <= rd_data_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_len_q <= frame_len_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end
  always_comb begin
    state_d = clr                   ? S_IDLE :
              start                 ? S_CAPTURE :
              state_q == S_CAPTURE  ? (term ? S_DONE : S_CAPTURE) :
              state_q == S_DONE     ? S_DONE : S_IDLE;
  end
  // Readback runs as a 3-stage pipe: request, RAM read, load rd_data.
  always_comb begin
    tready_d    = state_d == S_CAPTURE;
    wr_ptr_d    = (clr | start) ? '0 : (hs & ~at_end) ? wr_ptr_q + 1'b1 : wr_ptr_q;
    frame_len_d = (clr | start) ? '0 : hs ? frame_len_q + 1'b1 : frame_len_q;
    beat_cnt_d  = clr ? '0 : hs ? beat_cnt_q + 1'b1 : beat_cnt_q;
    done_d      = (clr | start) ? 1'b0 : term ? 1'b1 : done_q;
    ovf_d       = (clr | start) ? 1'b0 : (term & ~axis4_s_tlast) ? 1'b1 : ovf_q;
    rd_p1_d     = rd_req;
    rd_p2_d     = rd_p1_q & ~clr;
    rd_pend_d   = clr ? 1'b0 : rd_req ? 1'b1 : rd_p2_q ? 1'b0 : rd_pend_q;
    rd_data_d   = rd_p2_q ? ram_rd : rd_data_q;
    ie_d        = wr_ie ? avs_writedata[0] : ie_q;
    ctrl_d      = wr_ctrl ? (avs_writedata & CTRL_MASK)
                          : {1'b0, ctrl_q[30:2], ctrl_q[CTRL_RD_REQ] & ~rd_p2_q & ~ctrl_q[CTRL_CLR], 1'b0};
    stat = '0;
    stat[STAT_BUSY] = state_q == S_CAPTURE;
    stat[STAT_DONE] = done_q;
    stat[STAT_OVF] = ovf_q;
    stat[STAT_RD_PEND] = rd_pend_q;
    stat[STAT_RD_DATA +: 8] = rd_data_q;
    stat[STAT_LEN +: 13] = 13'(frame_len_q);
    dbg = {2'b00, state_q, 12'(wr_ptr_q), beat_cnt_q};
    avs_readdata = avs_address == CSR_CTRL ? ctrl_q :
                   avs_address == CSR_STAT ? stat :
                   avs_address == CSR_IE   ? {31'b0, ie_q} : dbg;
  end
  assign axis4_s_tready = tready_q;
  assign irq = done_q & ie_q;
endmodule

// File: tb/tb_fpga_data_sink.sv
// tb_fpga_data_sink: vector table, directed corner sequences and random frames against a buffer model.
module tb_fpga_data_sink;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] avs_address = '0;
  logic avs_chipselect = 1'b0, avs_write_n = 1'b1;
  logic [31:0] avs_writedata = '0, avs_readdata;
  logic [7:0] tdata = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tready, irq;
  fpga_data_sink dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write_n    (avs_write_n),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .axis4_s_tdata  (tdata),
    .axis4_s_tvalid (tvalid),
    .axis4_s_tlast  (tlast),
    .axis4_s_tready (tready),
    .irq            (irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[$];
  int n_chk = 0, n_pass = 0;
  logic [7:0] tx [0:4199];
  logic [7:0] mem_m [0:4095];
  logic [31:0] r;
  logic [7:0] d;
  logic p1, p3;
  int acc, rej, beat_m, hi, n, duty, a;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask
  task automatic csr_write(input logic [1:0] ad, input logic [31:0] wd);
    @(negedge clk);
    avs_address = ad;
    avs_writedata = wd;
    avs_chipselect = 1'b1;
    avs_write_n = 1'b0;
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_write_n = 1'b1;
  endtask
  task automatic peek(input logic [1:0] ad, output logic [31:0] q);
    avs_address = ad;
    #1 q = avs_readdata;
  endtask
  task automatic readback(input int ad, output logic [7:0] q, output logic pa, output logic pb);
    logic [31:0] s;
    csr_write(2'd0, (32'(ad) << 4) | 32'h2);
    peek(2'd1, s);
    pa = s[3];
    repeat (2) @(negedge clk);
    peek(2'd1, s);
    pb = s[3];
    q = s[15:8];
  endtask
  // Offers tx[0..cnt-1]; a byte stuck 4 valid cycles without tready counts as rejected.
  task automatic stream(input int cnt, input bit use_last, input int dty, output int ac, output int rj);
    int i, stall, cyc;
    i = 0; stall = 0; cyc = 0; ac = 0; rj = 0;
    while (i < cnt && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      tvalid = $urandom_range(0, 99) < dty;
      tdata = tx[i];
      tlast = use_last && i == cnt - 1;
      if (tvalid && tready) begin
        ac++; i++; stall = 0;
      end else if (tvalid) begin
        stall++;
        if (stall >= 4) begin rj++; i++; stall = 0; end
      end
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask
  initial begin
    vt.push_back('{1'b0, 2'd0, 32'h0, 32'h0, "rst_ctrl"});
    vt.push_back('{1'b0, 2'd1, 32'h0, 32'h0, "rst_stat"});
    vt.push_back('{1'b0, 2'd2, 32'h0, 32'h0, "rst_ie"});
    vt.push_back('{1'b0, 2'd3, 32'h0, 32'h0, "rst_dbg"});
    vt.push_back('{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h1, "ie_set"});
    vt.push_back('{1'b1, 2'd2, 32'hFFFF_FFFE, 32'h0, "ie_clr"});
    vt.push_back('{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0, "stat_wr_ign"});
    vt.push_back('{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, "dbg_wr_ign"});
    vt.push_back('{1'b1, 2'd0, 32'h0000_AB50, 32'h0000_AB50, "ctrl_rdaddr"});
    vt.push_back('{1'b1, 2'd0, 32'h0, 32'h0, "ctrl_zero"});
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_tready", 32'(tready), 0);
    check("rst_irq", 32'(irq), 0);
    foreach (vt[i]) begin
      if (vt[i].wr) csr_write(vt[i].addr, vt[i].wd);
      peek(vt[i].addr, r);
      check(vt[i].name, r, vt[i].exp);
    end
    // 5-byte frame with tvalid toggling
    csr_write(2'd2, 32'h1);
    csr_write(2'd0, 32'h1);
    peek(2'd1, r);
    check("arm_busy", 32'(r[0]), 1);
    check("arm_tready", 32'(tready), 1);
    for (int i = 0; i < 5; i++) tx[i] = 8'(8'h11 + i);
    stream(5, 1'b1, 50, acc, rej);
    check("f5_acc", acc, 5);
    peek(2'd1, r);
    check("f5_done_ovf_busy", 32'(r[2:0]), 32'b010);
    check("f5_len", 32'(r[28:16]), 5);
    check("f5_irq", 32'(irq), 1);
    check("f5_tready", 32'(tready), 0);
    readback(3, d, p1, p3);
    check("rb3_pend1", 32'(p1), 1);
    check("rb3_pend3", 32'(p3), 0);
    check("rb3_data", 32'(d), 32'h14);
    // overflow frame
    csr_write(2'd0, 32'h8000_0000);
    check("clr_irq", 32'(irq), 0);
    csr_write(2'd0, 32'h1);
    for (int i = 0; i < 4100; i++) tx[i] = 8'(i);
    stream(4100, 1'b0, 100, acc, rej);
    check("ovf_acc", acc, 4096);
    check("ovf_rej", rej, 4);
    peek(2'd1, r);
    check("ovf_flags", 32'(r[2:0]), 32'b110);
    check("ovf_len", 32'(r[28:16]), 4096);
    peek(2'd3, r);
    check("ovf_beat", 32'(r[15:0]), 4096);
    check("ovf_state", 32'(r[29:28]), 2);
    readback(4095, d, p1, p3);
    check("rb4095", 32'(d), 32'hFF);
    readback(1234, d, p1, p3);
    check("rb1234", 32'(d), 1234 % 256);
    // clr mid-frame then re-arm
    csr_write(2'd0, 32'h1);
    stream(10, 1'b0, 100, acc, rej);
    check("mid_acc", acc, 10);
    csr_write(2'd0, 32'h8000_0000);
    peek(2'd1, r);
    check("clr_busy", 32'(r[0]), 0);
    check("clr_done", 32'(r[1]), 0);
    check("clr_len", 32'(r[28:16]), 0);
    check("clr_tready", 32'(tready), 0);
    csr_write(2'd0, 32'h1);
    stream(2, 1'b1, 100, acc, rej);
    peek(2'd1, r);
    check("rearm_len", 32'(r[28:16]), 2);
    check("rearm_done", 32'(r[1]), 1);
    // clr|arm together, then arm while capturing
    csr_write(2'd0, 32'h8000_0001);
    peek(2'd1, r);
    check("clrarm_busy", 32'(r[0]), 0);
    check("clrarm_tready", 32'(tready), 0);
    csr_write(2'd0, 32'h1);
    stream(3, 1'b0, 100, acc, rej);
    csr_write(2'd0, 32'h1);
    peek(2'd1, r);
    check("arm_cap_len", 32'(r[28:16]), 3);
    check("arm_cap_busy", 32'(r[0]), 1);
    @(negedge clk);
    peek(2'd0, r);
    check("arm_cap_ctrl0", 32'(r[0]), 0);
    // random frames against the buffer model
    csr_write(2'd0, 32'h8000_0000);
    beat_m = 0;
    hi = 0;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 40);
      duty = $urandom_range(30, 100);
      for (int i = 0; i < n; i++) begin
        tx[i] = 8'($urandom);
        mem_m[i] = tx[i];
      end
      csr_write(2'd0, 32'h1);
      stream(n, 1'b1, duty, acc, rej);
      beat_m += n;
      if (n > hi) hi = n;
      check("rnd_acc", acc, n);
      peek(2'd1, r);
      check("rnd_len", 32'(r[28:16]), n);
      check("rnd_flags", 32'(r[2:0]), 32'b010);
      check("rnd_irq", 32'(irq), 1);
      peek(2'd3, r);
      check("rnd_beat", 32'(r[15:0]), beat_m % 65536);
      for (int k = 0; k < 3; k++) begin
        a = $urandom_range(0, hi - 1);
        readback(a, d, p1, p3);
        check("rnd_rd", 32'(d), 32'(mem_m[a]));
      end
    end
    // asynchronous reset mid-frame
    csr_write(2'd0, 32'h1);
    stream(4, 1'b0, 100, acc, rej);
    @(negedge clk);
    tvalid = 1'b1;
    tdata = 8'hAA;
    check("pre_rst_tready", 32'(tready), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_tready", 32'(tready), 0);
    check("arst_irq", 32'(irq), 0);
    peek(2'd1, r);
    check("arst_stat", r, 0);
    @(negedge clk);
    peek(2'd3, r);
    check("arst_dbg", r, 0);
    peek(2'd0, r);
    check("arst_ctrl", r, 0);
    peek(2'd2, r);
    check("arst_ie", r, 0);
    tvalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
